// File: rtl/axis_sample_pacer.sv
// axis_sample_pacer: paces 16-bit audio samples from a small FIFO onto an
// AXI-Stream master port, at most one sample per RATE_DIV clock cycles.
// Optional feature macro: AXIS_PACER_ZERO_FILL_EN. When it is defined, a tick
// that finds the FIFO empty emits a zero sample to keep the output cadence.
module axis_sample_pacer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RATE_DIV = 1134
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [DATA_W-1:0]        m_axis_data_tdata,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     underrun,
  output logic                     late
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned CntW  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                underrun_q, underrun_d;
  logic                late_q, late_d;
  logic                tick;
  logic                wr_en;
  logic                pop;

  assign tick     = (cnt_q == CntW'(RATE_DIV - 1));
  assign in_ready = (fill_q != FillW'(DEPTH));
  assign wr_en    = in_valid && in_ready;

  // Pace counter next state: free-running 0..RATE_DIV-1.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Pace counter register.
  always_ff @(posedge aclk) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO occupancy next state; a simultaneous write and pop cancel out.
  always_comb begin
    fill_d = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + FillW'(1);
    else if (!wr_en && pop) fill_d = fill_q - FillW'(1);
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fill_q <= fill_d;
    end
  end

  // Output FSM next state: load on tick from IDLE, hold in PRESENT until accepted.
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    underrun_d = underrun_q;
    late_d     = late_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          if (fill_q != '0) begin
            pop     = 1'b1;
            tdata_d = mem_q[rd_ptr_q];
            state_d = StPresent;
          end else begin
            underrun_d = 1'b1;
`ifdef AXIS_PACER_ZERO_FILL_EN
            tdata_d = '0;
            state_d = StPresent;
`endif
          end
        end
      end
      StPresent: begin
        if (m_axis_data_tready) state_d = StIdle;
        // A tick while presenting is dropped, even if the beat completes now.
        if (tick) late_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output FSM, data holding register and sticky flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      tdata_q    <= '0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      underrun_q <= underrun_d;
      late_q     <= late_d;
    end
  end

  assign m_axis_data_tvalid = (state_q == StPresent);
  assign m_axis_data_tdata  = tdata_q;
  assign fill               = fill_q;
  assign underrun           = underrun_q;
  assign late               = late_q;

endmodule

// File: tb/tb_axis_sample_pacer.sv
// Self-checking bench for axis_sample_pacer: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_axis_sample_pacer;

  localparam int unsigned DataW   = 16;
  localparam int unsigned Depth   = 4;
  localparam int unsigned RateDiv = 4;
  localparam int unsigned FillW   = $clog2(Depth) + 1;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic               in_valid = 1'b0;
  logic [DataW-1:0]   in_data = '0;
  logic               in_ready;
  logic               tvalid;
  logic               tready = 1'b0;
  logic [DataW-1:0]   tdata;
  logic [FillW-1:0]   fill;
  logic               underrun;
  logic               late;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [DataW-1:0] q[$];
  bit               m_valid;
  logic [DataW-1:0] m_data;
  bit               m_under;
  bit               m_late;
  int unsigned      m_cycle;

  logic [DataW-1:0] beats[$];

  axis_sample_pacer #(
    .DATA_W  (DataW),
    .DEPTH   (Depth),
    .RATE_DIV(RateDiv)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .m_axis_data_tvalid(tvalid),
    .m_axis_data_tready(tready),
    .m_axis_data_tdata (tdata),
    .fill              (fill),
    .underrun          (underrun),
    .late              (late)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one rising edge, using the inputs applied before it.
  task automatic model_edge();
    bit tick;
    bit wr;
    if (!aresetn) begin
      q.delete();
      m_valid = 0;
      m_data  = '0;
      m_under = 0;
      m_late  = 0;
      m_cycle = 0;
      return;
    end
    tick = (m_cycle % RateDiv) == RateDiv - 1;
    wr   = in_valid && (q.size() < Depth);
    if (m_valid) begin
      if (tready) m_valid = 0;
      if (tick) m_late = 1;
    end else if (tick) begin
      if (q.size() > 0) begin
        m_data  = q.pop_front();
        m_valid = 1;
      end else begin
        m_under = 1;
`ifdef AXIS_PACER_ZERO_FILL_EN
        m_data  = '0;
        m_valid = 1;
`endif
      end
    end
    if (wr) q.push_back(in_data);
    m_cycle++;
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    #1;
    check_eq("tvalid",   32'(tvalid),   32'(m_valid));
    check_eq("tdata",    32'(tdata),    32'(m_data));
    check_eq("fill",     32'(fill),     32'(q.size()));
    check_eq("in_ready", 32'(in_ready), 32'(q.size() != Depth));
    check_eq("underrun", 32'(underrun), 32'(m_under));
    check_eq("late",     32'(late),     32'(m_late));
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    in_valid = 1'b0;
    tready   = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!tvalid && k < budget) begin
      step();
      k++;
    end
    check_eq("wait_valid", 32'(tvalid), 32'd1);
  endtask

  task automatic write(input logic [DataW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    do_reset();
    check_eq("rst_tvalid",   32'(tvalid),   32'd0);
    check_eq("rst_tdata",    32'(tdata),    32'd0);
    check_eq("rst_fill",     32'(fill),     32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_flags",    32'({underrun, late}), 32'd0);

    // Basic pacing: three samples, one per tick.
    tready = 1'b1;
    write(16'h0001);
    write(16'h0002);
    write(16'h0003);
    check_eq("basic_fill3", 32'(fill), 32'd3);
    beats.delete();
    for (int i = 0; i < 14; i++) begin
      if (tvalid && tready) beats.push_back(tdata);
      step();
    end
    check_eq("basic_beats", 32'(beats.size()), 32'd3);
    for (int i = 0; i < beats.size(); i++) check_eq("basic_data", 32'(beats[i]), 32'(i + 1));
    check_eq("basic_fill0", 32'(fill), 32'd0);

    // Full FIFO: hold one sample unaccepted so no pops occur, then overfill.
    do_reset();
    write(16'hAAAA);
    wait_valid(2 * RateDiv);
    for (int i = 1; i <= 5; i++) write(16'(i));
    check_eq("full_fill", 32'(fill), 32'd4);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    tready = 1'b1;
    beats.delete();
    for (int i = 0; i < 6 * RateDiv; i++) begin
      if (tvalid && tready) beats.push_back(tdata);
      step();
    end
    check_eq("full_beats", 32'(beats.size()), 32'd5);
    for (int i = 1; i < beats.size(); i++) check_eq("full_data", 32'(beats[i]), 32'(i));

    // Backpressure: data held, late raised, next sample at a later tick.
    do_reset();
    write(16'h1234);
    write(16'h5678);
    wait_valid(2 * RateDiv);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("bp_hold_data", 32'(tdata), 32'h1234);
      check_eq("bp_hold_valid", 32'(tvalid), 32'd1);
    end
    check_eq("bp_late", 32'(late), 32'd1);
    tready = 1'b1;
    step();
    check_eq("bp_accept", 32'(tvalid), 32'd0);
    wait_valid(2 * RateDiv);
    check_eq("bp_next_data", 32'(tdata), 32'h5678);

    // Underrun: one tick with an empty FIFO.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < RateDiv; i++) step();
    check_eq("ur_flag", 32'(underrun), 32'd1);
`ifdef AXIS_PACER_ZERO_FILL_EN
    check_eq("ur_zero_valid", 32'(tvalid), 32'd1);
    check_eq("ur_zero_data", 32'(tdata), 32'd0);
`else
    check_eq("ur_no_valid", 32'(tvalid), 32'd0);
`endif

    // Reset while presenting with a partly full FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) write(16'h0100 + 16'(i));
    wait_valid(2 * RateDiv);
    check_eq("mr_fill3", 32'(fill), 32'd3);
    aresetn = 1'b0;
    step();
    check_eq("mr_tvalid", 32'(tvalid), 32'd0);
    check_eq("mr_fill", 32'(fill), 32'd0);
    check_eq("mr_flags", 32'({underrun, late}), 32'd0);
    aresetn = 1'b1;
    tready  = 1'b1;
    for (int i = 0; i < 2 * RateDiv; i++) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      aresetn  = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 16'($urandom_range(0, 65535));
      tready   = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_sample_pacer.md
# axis_sample_pacer

- Sources 16-bit audio samples onto the AXI-Stream slave input of the noise-filter block (`s_axis_data_*` on the filter side).
- Accepts samples from a producer through a simple valid/ready write port into a small FIFO.
- Emits at most one sample per sample period (44.1 kHz from a 50 MHz `aclk`), honouring backpressure from the filter.
- Is the synthesizable stream master that replaces the file-driven stimulus in front of the filter.

## Interface
- `DATA_W`, 16: sample width.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `RATE_DIV`, 1134: `aclk` cycles per sample period.
- `aclk` in 1: clock; everything is on the rising edge.
- `aresetn` in 1: synchronous reset, active-low.
- `in_valid` in 1: producer offers `in_data`.
- `in_data` in DATA_W: sample from the producer.
- `in_ready` out 1: FIFO can accept a sample (not full).
- `m_axis_data_tvalid` out 1: output sample valid.
- `m_axis_data_tready` in 1: filter accepts the sample.
- `m_axis_data_tdata` out DATA_W: output sample.
- `fill` out $clog2(DEPTH)+1: FIFO occupancy.
- `underrun` out 1: sticky; a tick found no sample.
- `late` out 1: sticky; a tick arrived while the previous sample was still unaccepted.

## Operation
**Reset values** (when `aresetn`=0 at a rising edge):
- `m_axis_data_tvalid`=0, `m_axis_data_tdata`=0, `fill`=0, `underrun`=0, `late`=0.
- `in_ready`=1, pace counter=0, state=IDLE.

**Pace counter**
- Free-running, counts 0..RATE_DIV-1 and wraps to 0.
- `tick` is asserted for the one cycle in which count==RATE_DIV-1.

**FIFO**
- Circular buffer with `DEPTH` entries and write/read pointers that wrap modulo DEPTH.
- A write happens when `in_valid && in_ready`.
- A pop happens only on the IDLE→PRESENT load.
- `in_ready` = (`fill` != DEPTH), evaluated from the registered `fill`.
- Write and pop in the same cycle: `fill` is unchanged and both complete.
- A write attempted while full is ignored; no state changes.

**State machine**
- IDLE, on tick:
  - FIFO non-empty: pop the head into `m_axis_data_tdata`, set `tvalid`, go to PRESENT.
  - FIFO empty: set `underrun`; behaviour then depends on the configuration macro.
- IDLE, no tick: stay.
- PRESENT, `tvalid && tready`: clear `tvalid`, go to IDLE.
- PRESENT, tick while not accepted: set `late`. The tick is dropped, not queued. Stay in PRESENT with `tdata`/`tvalid` held stable.
- PRESENT, tick and `tready` in the same cycle: the handshake completes, `late` is set, and no new load happens that cycle.

**AXI rules**
- `tdata` is stable while `tvalid`=1 and `tready`=0.
- `tvalid` never depends combinationally on `tready`.

**Sticky flags**
- `underrun` and `late` clear only on reset.

**Mid-operation reset**
- Discards FIFO contents and any pending output, and deasserts `tvalid` the following cycle.

## Timing
- Tick in cycle T → `tvalid`=1 and `tdata` valid from cycle T+1.
- Handshake in cycle H → `tvalid`=0 from H+1.
- Earliest next sample is at the next tick, RATE_DIV cycles after the previous tick.
- FIFO write latency: a sample written in cycle W can be popped by a tick in cycle W+1 or later.
- A tick in the same cycle as the write sees the FIFO as empty.
- `fill` and `in_ready` update one cycle after the write or pop.

## Configuration
- `AXIS_PACER_ZERO_FILL_EN` defined:
  - On an underrun tick, load `tdata`=0, set `tvalid`, and go to PRESENT.
  - Output cadence is preserved (silence insertion).
  - `underrun` is still set.
- Not defined:
  - On an underrun tick, stay in IDLE and emit nothing for that period.

## Test plan
- **Basic pacing**: RATE_DIV=4, DEPTH=4, `tready`=1, write 0x0001,0x0002,0x0003 before the first tick → `tvalid` pulses one cycle each at ticks 1..3, data 0x0001,0x0002,0x0003, each 4 cycles apart; `fill` goes 3→0.
- **Full FIFO**: write 5 samples back-to-back with no tick, DEPTH=4 → `in_ready`=0 after the 4th; the 5th (0x0005) is dropped; `fill`=4.
- **Backpressure**: `tready`=0 for 6 cycles after first `tvalid` with data 0x1234 → `tdata` held at 0x1234; `late`=1 at the next tick; accepted on `tready`=1; next sample appears at the following tick.
- **Underrun**: empty FIFO, one tick → `underrun`=1. With `AXIS_PACER_ZERO_FILL_EN`: one `tvalid` beat with data 0x0000. Without it: `tvalid` stays 0.
- **Simultaneous write and pop**: `fill`=2, write in the tick cycle → `fill` remains 2; the popped data is the oldest entry.
- **Reset mid-operation**: `aresetn`=0 while in PRESENT with `fill`=3 → next cycle `tvalid`=0, `fill`=0, flags 0; after release, first `tvalid` occurs only after a new write plus a tick.
